// File: rtl/esdi_sector_decoder.sv
// Purpose: ESDI read-field decoder. Hunts the sync mark, checks CRC-16/CCITT,
//          emits header words in parallel and data fields as a byte stream.
// Latency: header word one cycle after the low CRC byte; data bytes trail input by one payload byte.
// Backpressure: s_tready drops only in data fields, when the output register is full and stalled.
//
// Ports:
//   sector_aclk / sector_aresetn          clock, async active-low reset
//   enable                                0 = hold in HUNT, swallow input
//   field_is_data                         field type, sampled on the sync byte
//   s_tvalid/s_tready/s_tdata/s_tlast     byte input from the deserializer
//   m_tvalid/m_tready/m_tdata/m_tlast/m_tuser  data-field byte output, m_tuser = error on last byte
//   hdr_valid/hdr_data/hdr_crc_ok         header word, one-cycle pulse
//   sync_miss_count / crc_err_count       saturating error counters
module esdi_sector_decoder #(
    parameter logic [7:0]  SYNC_BYTE    = 8'h01,
    parameter int          HEADER_BYTES = 4,
    parameter int          DATA_BYTES   = 512,
    parameter logic [15:0] CRC_INIT     = 16'hFFFF
) (
    input  logic                      sector_aclk,
    input  logic                      sector_aresetn,
    input  logic                      enable,
    input  logic                      field_is_data,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [7:0]                s_tdata,
    input  logic                      s_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [7:0]                m_tdata,
    output logic                      m_tlast,
    output logic                      m_tuser,
    output logic                      hdr_valid,
    output logic [8*HEADER_BYTES-1:0] hdr_data,
    output logic                      hdr_crc_ok,
    output logic [15:0]               sync_miss_count,
    output logic [15:0]               crc_err_count
);
    localparam int HW   = 8 * HEADER_BYTES;
    localparam int MAXN = (DATA_BYTES > HEADER_BYTES) ? DATA_BYTES : HEADER_BYTES;
    localparam int CW   = $clog2(MAXN + 1);
    localparam logic [CW-1:0] HDR_LAST  = CW'(HEADER_BYTES - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);

    typedef enum logic [2:0] {HUNT, PAYLOAD, CRC_HI, CRC_LO, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_data_q, is_data_d;
    logic [15:0]     crc_q, crc_d;
    logic [7:0]      crc_hi_q, crc_hi_d;
    logic [HW-1:0]   shift_q, shift_d;
    logic [7:0]      pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic            m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d, m_tuser_q, m_tuser_d;
    logic [7:0]      m_tdata_q, m_tdata_d;
    logic            hdr_valid_q, hdr_valid_d, hdr_crc_ok_q, hdr_crc_ok_d;
    logic [HW-1:0]   hdr_data_q, hdr_data_d;
    logic [15:0]     miss_q, miss_d, err_q, err_d;

    logic            out_free, data_busy, s_hs;
    logic            miss_inc, fin, fin_err;
    logic [HW+7:0]   shift_cat;
    logic [CW-1:0]   last_idx;

    // One byte of CRC-16/CCITT, MSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign out_free  = !m_tvalid_q || m_tready;
    // Every data-field byte may need to push something into the output register
    // (pending release, truncation marker, zero-length marker), so the input waits
    // for room whenever a data field is open.
    assign data_busy = is_data_q && (state_q == PAYLOAD || state_q == CRC_HI || state_q == CRC_LO);
    assign s_tready  = sector_aresetn && (!enable || !data_busy || out_free);
    assign s_hs      = s_tvalid && s_tready;
    assign shift_cat = {shift_q, s_tdata};
    assign last_idx  = is_data_q ? DATA_LAST : HDR_LAST;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_data_d    = is_data_q;
        crc_d        = crc_q;
        crc_hi_d     = crc_hi_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        m_tvalid_d   = m_tvalid_q && !m_tready;
        m_tdata_d    = m_tdata_q;
        m_tlast_d    = m_tlast_q;
        m_tuser_d    = m_tuser_q;
        hdr_valid_d  = 1'b0;
        hdr_data_d   = hdr_data_q;
        hdr_crc_ok_d = hdr_crc_ok_q;
        miss_inc     = 1'b0;
        fin          = 1'b0;
        fin_err      = 1'b0;

        if (!enable) begin
            state_d    = HUNT;
            pend_vld_d = 1'b0;
        end else if (s_hs) begin
            unique case (state_q)
                HUNT: begin
                    if (s_tlast) begin
                        miss_inc = 1'b1;
                    end else if (s_tdata == SYNC_BYTE) begin
                        state_d    = PAYLOAD;
                        is_data_d  = field_is_data;
                        cnt_d      = '0;
                        crc_d      = CRC_INIT;
                        shift_d    = '0;
                        pend_vld_d = 1'b0;
                    end else if (s_tdata != 8'h00) begin
                        miss_inc = 1'b1;
                        state_d  = DRAIN;
                    end
                end
                PAYLOAD: begin
                    if (s_tlast) begin
                        // A tlast byte here is a truncation marker, not payload.
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        crc_d = crc_byte(crc_q, s_tdata);
                        cnt_d = cnt_q + CW'(1);
                        if (is_data_q) begin
                            if (pend_vld_q) begin
                                m_tvalid_d = 1'b1;
                                m_tdata_d  = pend_q;
                                m_tlast_d  = 1'b0;
                                m_tuser_d  = 1'b0;
                            end
                            pend_d     = s_tdata;
                            pend_vld_d = 1'b1;
                        end else begin
                            shift_d = shift_cat[HW-1:0];
                        end
                        if (cnt_q == last_idx) state_d = CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (s_tlast) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        crc_hi_d = s_tdata;
                        state_d  = CRC_LO;
                    end
                end
                CRC_LO: begin
                    fin     = 1'b1;
                    fin_err = (crc_q != {crc_hi_q, s_tdata});
                    state_d = s_tlast ? HUNT : DRAIN;
                end
                DRAIN: begin
                    if (s_tlast) state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end

        if (fin) begin
            if (state_q != CRC_LO) state_d = HUNT;
            if (is_data_q) begin
                // Zero-length truncated data field still closes the stream with a 0x00 byte.
                m_tvalid_d = 1'b1;
                m_tdata_d  = pend_vld_q ? pend_q : 8'h00;
                m_tlast_d  = 1'b1;
                m_tuser_d  = fin_err;
                pend_vld_d = 1'b0;
            end else begin
                hdr_valid_d  = 1'b1;
                hdr_data_d   = shift_q;
                hdr_crc_ok_d = !fin_err;
            end
        end

        miss_d = (miss_inc && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
        err_d  = (fin && fin_err && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    always_ff @(posedge sector_aclk or negedge sector_aresetn) begin
        if (!sector_aresetn) begin
            state_q      <= HUNT;
            cnt_q        <= '0;
            is_data_q    <= 1'b0;
            crc_q        <= CRC_INIT;
            crc_hi_q     <= 8'h00;
            shift_q      <= '0;
            pend_q       <= 8'h00;
            pend_vld_q   <= 1'b0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= 8'h00;
            m_tlast_q    <= 1'b0;
            m_tuser_q    <= 1'b0;
            hdr_valid_q  <= 1'b0;
            hdr_data_q   <= '0;
            hdr_crc_ok_q <= 1'b0;
            miss_q       <= 16'h0000;
            err_q        <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_data_q    <= is_data_d;
            crc_q        <= crc_d;
            crc_hi_q     <= crc_hi_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            m_tuser_q    <= m_tuser_d;
            hdr_valid_q  <= hdr_valid_d;
            hdr_data_q   <= hdr_data_d;
            hdr_crc_ok_q <= hdr_crc_ok_d;
            miss_q       <= miss_d;
            err_q        <= err_d;
        end
    end

    assign m_tvalid        = m_tvalid_q;
    assign m_tdata         = m_tdata_q;
    assign m_tlast         = m_tlast_q;
    assign m_tuser         = m_tuser_q;
    assign hdr_valid       = hdr_valid_q;
    assign hdr_data        = hdr_data_q;
    assign hdr_crc_ok      = hdr_crc_ok_q;
    assign sync_miss_count = miss_q;
    assign crc_err_count   = err_q;
endmodule

// File: tb/tb_esdi_sector_decoder.sv
// Bench for esdi_sector_decoder with a 9-byte header and a 4-byte data field.
// Directed scenarios use fixed expected values; the random scenario uses a packet-level model.
// m_tready is driven always-low, always-high or randomly depending on rdy_mode.
module tb_esdi_sector_decoder;
    localparam int HB = 9;
    localparam int DB = 4;
    localparam logic [7:0] SYNC = 8'h01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sector_aresetn, enable, field_is_data;
    logic        s_tvalid, s_tready, s_tlast;
    logic [7:0]  s_tdata;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic [7:0]  m_tdata;
    logic        hdr_valid, hdr_crc_ok;
    logic [71:0] hdr_data;
    logic [15:0] sync_miss_count, crc_err_count;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 1;
    int stab_viol = 0;
    int exp_miss = 0;
    int exp_err = 0;

    logic [7:0]  pkt[$];
    logic [9:0]  out_q[$];
    logic [9:0]  exp_out[$];
    logic [72:0] hdr_q[$];
    logic [72:0] exp_hdr[$];
    bit          exp_hdr_full[$];

    esdi_sector_decoder #(
        .SYNC_BYTE(SYNC), .HEADER_BYTES(HB), .DATA_BYTES(DB), .CRC_INIT(16'hFFFF)
    ) dut (
        .sector_aclk(clk), .sector_aresetn(sector_aresetn), .enable(enable),
        .field_is_data(field_is_data),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_crc_ok(hdr_crc_ok),
        .sync_miss_count(sync_miss_count), .crc_err_count(crc_err_count)
    );

    initial begin : ready_drv
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        logic       prev_stall;
        logic [9:0] prev_v;
        prev_stall = 1'b0;
        prev_v = '0;
        forever begin
            @(negedge clk);
            if (!sector_aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!m_tvalid || {m_tlast, m_tuser, m_tdata} !== prev_v)) stab_viol++;
                if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tuser, m_tdata});
                if (hdr_valid) hdr_q.push_back({hdr_crc_ok, hdr_data});
                prev_stall = m_tvalid && !m_tready;
                prev_v = {m_tlast, m_tuser, m_tdata};
            end
        end
    end

    // Bit-serial CRC-16/CCITT, preset 0xFFFF.
    function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        foreach (d[k]) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ d[k][j];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // Expected outcome of the packet in pkt, appended to exp_* and the running counters.
    task automatic model(input bit is_data);
        int n, i, t, nf, npay;
        logic [7:0] pay[$];
        logic [15:0] rx;
        logic [71:0] hd;
        bit err;
        n = pkt.size();
        i = 0;
        while (i < n - 1 && pkt[i] == 8'h00) i++;
        if (pkt[i] != SYNC || i == n - 1) begin
            exp_miss++;
            return;
        end
        t = n - 2 - i;
        nf = is_data ? DB : HB;
        err = 1'b1;
        npay = (t < nf) ? t : nf;
        for (int k = 0; k < npay; k++) pay.push_back(pkt[i + 1 + k]);
        if (t > nf) begin
            rx = {pkt[i + 1 + nf], pkt[i + 2 + nf]};
            err = (ref_crc(pay) != rx);
        end
        if (err) exp_err++;
        if (is_data) begin
            if (npay == 0) exp_out.push_back({1'b1, 1'b1, 8'h00});
            for (int k = 0; k < npay; k++)
                exp_out.push_back({k == npay - 1, (k == npay - 1) && err, pay[k]});
        end else begin
            hd = '0;
            foreach (pay[k]) hd = {hd[63:0], pay[k]};
            exp_hdr.push_back({!err, hd});
            exp_hdr_full.push_back(npay == nf);
        end
    endtask

    task automatic clear_q();
        out_q.delete(); hdr_q.delete(); exp_out.delete(); exp_hdr.delete(); exp_hdr_full.delete();
    endtask

    // Called aligned to posedge+1; returns aligned to posedge+1 after the handshake.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        bit hs;
        s_tvalid = 1'b1; s_tdata = b; s_tlast = last;
        n = 0; hs = 1'b0;
        while (!hs && n < 500) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) begin
            checks++; failures++;
            $display("FAIL send_timeout byte=%h s_tready stuck at 0, required 1", b);
        end
    endtask

    task automatic send_pkt(input bit is_data, input bit gaps);
        field_is_data = is_data;
        @(posedge clk);
        #1;
        foreach (pkt[k]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            send_byte(pkt[k], k == pkt.size() - 1);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic drain();
        int n, quiet;
        n = 0; quiet = 0;
        while (quiet < 4 && n < 300) begin
            @(negedge clk);
            n++;
            if (!m_tvalid) quiet++; else quiet = 0;
        end
        if (quiet < 4) begin
            checks++; failures++;
            $display("FAIL drain_timeout m_tvalid still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic test_reset();
        sector_aresetn = 1'b0; enable = 1'b1; field_is_data = 1'b0;
        s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
        #12;
        checks++;
        if ({m_tvalid, m_tdata, m_tlast, m_tuser, hdr_valid, hdr_crc_ok, s_tready} !== 13'h0) begin
            failures++; $display("FAIL reset_outputs got=%h required=0",
                {m_tvalid, m_tdata, m_tlast, m_tuser, hdr_valid, hdr_crc_ok, s_tready});
        end
        checks++;
        if ({hdr_data, sync_miss_count, crc_err_count} !== 104'h0) begin
            failures++; $display("FAIL reset_data_counters got=%h required=0",
                {hdr_data, sync_miss_count, crc_err_count});
        end
        repeat (2) @(negedge clk);
        sector_aresetn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            failures++; $display("FAIL hunt_ready got=%b%b required=10", s_tready, m_tvalid);
        end
    endtask

    task automatic test_header(input logic [7:0] crc_lo, input bit ok);
        clear_q();
        pkt = '{8'h00, 8'h00, 8'h01, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'h29, 8'h00};
        pkt[13] = crc_lo;
        if (!ok) exp_err++;
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (hdr_q.size() !== 1) begin
            failures++; $display("FAIL hdr_count got=%0d required=1", hdr_q.size());
        end else begin
            checks++;
            if (hdr_q[0] !== {ok, 72'h313233343536373839}) begin
                failures++; $display("FAIL hdr_word got=%h required=%h", hdr_q[0], {ok, 72'h313233343536373839});
            end
        end
        checks++;
        if (sync_miss_count !== 16'(exp_miss) || crc_err_count !== 16'(exp_err) || out_q.size() != 0) begin
            failures++; $display("FAIL hdr_counters got miss=%0d err=%0d outs=%0d required %0d %0d 0",
                sync_miss_count, crc_err_count, out_q.size(), exp_miss, exp_err);
        end
    endtask

    task automatic test_sync_miss();
        clear_q();
        pkt = '{8'h00, 8'h00, 8'h7E, 8'h12, 8'h34};
        exp_miss++;
        send_pkt(1'b1, 1'b0);
        drain();
        checks++;
        if (sync_miss_count !== 16'(exp_miss) || out_q.size() != 0 || hdr_q.size() != 0) begin
            failures++; $display("FAIL sync_miss got miss=%0d outs=%0d hdrs=%0d required %0d 0 0",
                sync_miss_count, out_q.size(), hdr_q.size(), exp_miss);
        end
        test_header(8'hB1, 1'b1);
    endtask

    task automatic test_data_bp(input string name);
        logic [7:0] pay[$];
        logic [15:0] c;
        clear_q();
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        c = ref_crc(pay);
        pkt = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00};
        pkt[6] = c[15:8]; pkt[7] = c[7:0];
        rdy_mode = 2;
        send_pkt(1'b1, 1'b1);
        drain();
        checks++;
        if (out_q.size() !== 4) begin
            failures++; $display("FAIL %s count got=%0d required=4", name, out_q.size());
        end else begin
            foreach (pay[k]) begin
                checks++;
                if (out_q[k] !== {k == 3, 1'b0, pay[k]}) begin
                    failures++; $display("FAIL %s byte%0d got=%h required=%h", name, k, out_q[k], {k == 3, 1'b0, pay[k]});
                end
            end
        end
        checks++;
        if (stab_viol !== 0 || crc_err_count !== 16'(exp_err)) begin
            failures++; $display("FAIL %s hold_err got viol=%0d err=%0d required 0 %0d", name, stab_viol, crc_err_count, exp_err);
        end
    endtask

    task automatic test_truncated();
        clear_q();
        rdy_mode = 2;
        pkt = '{8'h01, 8'hAA, 8'hBB, 8'h77};
        exp_err++;
        send_pkt(1'b1, 1'b0);
        drain();
        checks++;
        if (out_q.size() !== 2 || out_q[0] !== 10'h0AA || out_q[1] !== 10'h3BB) begin
            failures++; $display("FAIL trunc_data got n=%0d %h %h required 2 0aa 3bb",
                out_q.size(), out_q.size() > 0 ? out_q[0] : 10'h0, out_q.size() > 1 ? out_q[1] : 10'h0);
        end
        clear_q();
        pkt = '{8'h00, 8'h01, 8'h5A};
        exp_err++;
        send_pkt(1'b1, 1'b0);
        drain();
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== 10'h300) begin
            failures++; $display("FAIL zero_trunc got n=%0d %h required 1 300",
                out_q.size(), out_q.size() > 0 ? out_q[0] : 10'h0);
        end
        checks++;
        if (crc_err_count !== 16'(exp_err)) begin
            failures++; $display("FAIL trunc_err_count got=%0d required=%0d", crc_err_count, exp_err);
        end
    endtask

    task automatic test_hunt_edges();
        clear_q();
        pkt = '{8'h00, 8'h01};
        exp_miss++;
        send_pkt(1'b0, 1'b0);
        pkt = '{8'h00};
        exp_miss++;
        send_pkt(1'b1, 1'b0);
        drain();
        checks++;
        if (sync_miss_count !== 16'(exp_miss) || hdr_q.size() != 0 || out_q.size() != 0) begin
            failures++; $display("FAIL hunt_tlast got miss=%0d hdrs=%0d outs=%0d required %0d 0 0",
                sync_miss_count, hdr_q.size(), out_q.size(), exp_miss);
        end
    endtask

    task automatic test_enable();
        clear_q();
        rdy_mode = 1;
        field_is_data = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        s_tvalid = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        exp_miss++;
        drain();
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== 10'h0AA) begin
            failures++; $display("FAIL enable_abandon got n=%0d %h required 1 0aa",
                out_q.size(), out_q.size() > 0 ? out_q[0] : 10'h0);
        end
        checks++;
        if (sync_miss_count !== 16'(exp_miss) || crc_err_count !== 16'(exp_err)) begin
            failures++; $display("FAIL enable_counters got %0d %0d required %0d %0d",
                sync_miss_count, crc_err_count, exp_miss, exp_err);
        end
    endtask

    task automatic test_random(input int npkts);
        bit is_data, bad;
        int mode, nf;
        logic [7:0] pay[$];
        logic [15:0] c;
        rdy_mode = 2;
        for (int p = 0; p < npkts; p++) begin
            clear_q();
            pkt.delete(); pay.delete();
            is_data = 1'($urandom_range(0, 1));
            nf = is_data ? DB : HB;
            mode = $urandom_range(0, 6);
            repeat ($urandom_range(0, 3)) pkt.push_back(8'h00);
            case (mode)
                3: begin
                    pkt.push_back(SYNC);
                    repeat ($urandom_range(0, nf)) pkt.push_back(8'($urandom));
                    pkt.push_back(8'($urandom));
                end
                4: begin
                    pkt.push_back(8'($urandom_range(2, 255)));
                    repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
                end
                6: pkt.push_back(8'h00);
                default: begin
                    pkt.push_back(SYNC);
                    repeat (nf) pay.push_back(8'($urandom));
                    c = ref_crc(pay);
                    if (mode == 2) c = c ^ (16'h1 << $urandom_range(0, 15));
                    foreach (pay[k]) pkt.push_back(pay[k]);
                    pkt.push_back(c[15:8]);
                    pkt.push_back(c[7:0]);
                    if (mode == 5) repeat ($urandom_range(1, 3)) pkt.push_back(8'($urandom));
                end
            endcase
            model(is_data);
            send_pkt(is_data, 1'b1);
            drain();
            checks++;
            bad = (out_q.size() != exp_out.size());
            if (!bad) foreach (exp_out[k]) if (out_q[k] !== exp_out[k]) bad = 1'b1;
            if (bad) begin
                failures++; $display("FAIL rand_out pkt=%0d mode=%0d got n=%0d first=%h required n=%0d first=%h",
                    p, mode, out_q.size(), out_q.size() > 0 ? out_q[0] : 10'h0,
                    exp_out.size(), exp_out.size() > 0 ? exp_out[0] : 10'h0);
            end
            checks++;
            bad = (hdr_q.size() != exp_hdr.size());
            if (!bad) foreach (exp_hdr[k]) begin
                if (hdr_q[k][72] !== exp_hdr[k][72]) bad = 1'b1;
                if (exp_hdr_full[k] && hdr_q[k] !== exp_hdr[k]) bad = 1'b1;
            end
            if (bad) begin
                failures++; $display("FAIL rand_hdr pkt=%0d mode=%0d got n=%0d w=%h required n=%0d w=%h",
                    p, mode, hdr_q.size(), hdr_q.size() > 0 ? hdr_q[0] : 73'h0,
                    exp_hdr.size(), exp_hdr.size() > 0 ? exp_hdr[0] : 73'h0);
            end
            checks++;
            if (sync_miss_count !== 16'(exp_miss) || crc_err_count !== 16'(exp_err)) begin
                failures++; $display("FAIL rand_counters pkt=%0d got %0d %0d required %0d %0d",
                    p, sync_miss_count, crc_err_count, exp_miss, exp_err);
            end
        end
        checks++;
        if (stab_viol !== 0) begin
            failures++; $display("FAIL rand_output_hold got=%0d required=0", stab_viol);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        rdy_mode = 0;
        field_is_data = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        s_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hAA) begin
            failures++; $display("FAIL pre_reset_stall got=%b %h required 1 aa", m_tvalid, m_tdata);
        end
        sector_aresetn = 1'b0;
        #1;
        checks++;
        if ({m_tvalid, m_tdata, m_tlast, m_tuser, hdr_valid, hdr_crc_ok, s_tready,
             hdr_data, sync_miss_count, crc_err_count} !== 117'h0) begin
            failures++; $display("FAIL mid_reset_outputs got=%h required=0",
                {m_tvalid, m_tdata, m_tlast, m_tuser, hdr_valid, hdr_crc_ok, s_tready,
                 hdr_data, sync_miss_count, crc_err_count});
        end
        exp_miss = 0; exp_err = 0;
        repeat (2) @(negedge clk);
        sector_aresetn = 1'b1;
        test_data_bp("post_reset");
    endtask

    initial begin
        test_reset();
        test_header(8'hB1, 1'b1);
        test_header(8'hB0, 1'b0);
        test_sync_miss();
        test_data_bp("data_bp");
        test_truncated();
        test_hunt_edges();
        test_enable();
        test_random(40);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
